// File: rtl/hacd_pkg.sv
// Shared HACD types: AXI write channel bundles, write-arbiter FSM states and requester indices.
package hacd_pkg;

  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_STRB_W = AXI_DATA_W / 8;

  localparam int REQ_PGWR = 0;
  localparam int REQ_CWB  = 1;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA
  } wr_arb_state_t;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] awaddr;
    logic                  awvalid;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
  } axi_wr_reqpkt_t;

  typedef struct packed {
    logic awready;
    logic wready;
  } axi_wr_rdypkt_t;

  typedef struct packed {
    logic       bvalid;
    logic [1:0] bresp;
  } axi_wr_resppkt_t;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hawk_wr_arb_idfifo.sv
// In-order FIFO holding the requester index of every issued AW until its B response returns.
module hawk_wr_arb_idfifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       din_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       dout_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/hawk_wr_arbiter.sv
// Shares the HAWK AXI write master among NUM_REQ requesters, keeping AW+W atomic and routing B in order.
// Build option: HAWK_WR_ARB_FIXED_PRIO_EN selects fixed lowest-index priority instead of round-robin.
module hawk_wr_arbiter
  import hacd_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int RESP_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NUM_REQ-1:0]          req_i,
  input  axi_wr_reqpkt_t              req_wr_i   [NUM_REQ],
  output axi_wr_rdypkt_t              req_rdy_o  [NUM_REQ],
  output axi_wr_resppkt_t             req_resp_o [NUM_REQ],
  output axi_wr_reqpkt_t              m_wr_o,
  input  axi_wr_rdypkt_t              m_rdy_i,
  input  axi_wr_resppkt_t             m_resp_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [$clog2(RESP_DEPTH):0] outstanding_o,
  output logic                        err_o
);

  localparam int IDX_W = idx_width(NUM_REQ);

  wr_arb_state_t    state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d, sel_idx, head_idx;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic             sel_found, fifo_full, fifo_empty, push, pop, w_hs, err_q;
  axi_wr_reqpkt_t   own_wr;

  assign own_wr = req_wr_i[owner_q];
  assign push   = (state_q == ADDR) && own_wr.awvalid && m_rdy_i.awready && !fifo_full;
  assign w_hs   = (state_q == DATA) && own_wr.wvalid && m_rdy_i.wready;
  assign pop    = m_resp_i.bvalid && !fifo_empty;

`ifdef HAWK_WR_ARB_FIXED_PRIO_EN
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        sel_found = 1'b1;
        sel_idx   = IDX_W'(i);
      end
    end
  end
`else
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d, cand;
  logic [IDX_W:0]   cand_sum;

  // Search starts at rr_ptr and wraps; sums stay below 2*NUM_REQ so one subtract suffices.
  always_comb begin
    sel_idx   = '0;
    sel_found = 1'b0;
    cand_sum  = '0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand_sum = {1'b0, rr_ptr_q} + (IDX_W + 1)'(i);
      if (cand_sum >= (IDX_W + 1)'(NUM_REQ)) cand_sum = cand_sum - (IDX_W + 1)'(NUM_REQ);
      cand = cand_sum[IDX_W-1:0];
      if (!sel_found && req_i[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (w_hs) rr_ptr_d = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= '0;
    else         rr_ptr_q <= rr_ptr_d;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          owner_d = sel_idx;
          grant_d = NUM_REQ'(1) << sel_idx;
          state_d = ADDR;
        end
      end
      ADDR: begin
        if (push) begin
          state_d = DATA;
        end else if (!req_i[owner_q] && !own_wr.awvalid) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      DATA: begin
        if (w_hs) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      owner_q <= '0;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      grant_q <= grant_d;
    end
  end

  // Channel muxing is purely combinational; only the owner ever sees a ready.
  always_comb begin
    m_wr_o = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_rdy_o[i]  = '0;
      req_resp_o[i] = '0;
    end
    case (state_q)
      ADDR: begin
        m_wr_o         = own_wr;
        m_wr_o.awvalid = own_wr.awvalid && !fifo_full;
        m_wr_o.wvalid  = 1'b0;
        req_rdy_o[owner_q].awready = m_rdy_i.awready && !fifo_full;
      end
      DATA: begin
        m_wr_o         = own_wr;
        m_wr_o.awvalid = 1'b0;
        req_rdy_o[owner_q].wready = m_rdy_i.wready;
      end
      default: ;
    endcase
    if (pop) begin
      req_resp_o[head_idx].bvalid = 1'b1;
      req_resp_o[head_idx].bresp  = m_resp_i.bresp;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_q <= 1'b0;
    else if (m_resp_i.bvalid && (fifo_empty || (m_resp_i.bresp != 2'b00))) err_q <= 1'b1;
  end

  hawk_wr_arb_idfifo #(
    .WIDTH (IDX_W),
    .DEPTH (RESP_DEPTH)
  ) u_idfifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .din_i   (owner_q),
    .pop_i   (pop),
    .dout_o  (head_idx),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outstanding_o)
  );

  assign grant_o = grant_q;
  assign err_o   = err_q;

endmodule

// File: tb/tb_hawk_wr_arbiter.sv
// Directed bench for hawk_wr_arbiter: arbitration, AW/W atomicity, ID FIFO limits, B routing, errors, reset.
module tb_hawk_wr_arbiter;
  import hacd_pkg::*;

  logic            clk = 1'b0;
  logic            rst_ni = 1'b0;
  logic [1:0]      req;
  axi_wr_reqpkt_t  req_wr   [2];
  axi_wr_rdypkt_t  req_rdy  [2];
  axi_wr_resppkt_t req_resp [2];
  axi_wr_reqpkt_t  m_wr;
  axi_wr_rdypkt_t  m_rdy;
  axi_wr_resppkt_t m_resp;
  logic [1:0]      grant;
  logic [3:0]      outstanding;
  logic            err;
  int              checks = 0;
  int              errors = 0;

  always #5 clk = ~clk;

  hawk_wr_arbiter #(.NUM_REQ(2), .RESP_DEPTH(8)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .req_i         (req),
    .req_wr_i      (req_wr),
    .req_rdy_o     (req_rdy),
    .req_resp_o    (req_resp),
    .m_wr_o        (m_wr),
    .m_rdy_i       (m_rdy),
    .m_resp_i      (m_resp),
    .grant_o       (grant),
    .outstanding_o (outstanding),
    .err_o         (err)
  );

  task automatic clear_inputs();
    req = '0;
    for (int i = 0; i < 2; i++) req_wr[i] = '0;
    m_rdy  = '0;
    m_resp = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_ni = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_ni = 1'b0;
    req = 2'b11;
    req_wr[0].awvalid = 1'b1;
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    @(negedge clk);
    @(negedge clk);
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got %b exp 00", grant); end
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL reset_outstanding got %0d exp 0", outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", err); end
    checks++; if (m_wr !== '0) begin errors++; $display("FAIL reset_m_wr got %h exp 0", m_wr); end
    checks++; if ({req_rdy[0], req_rdy[1], req_resp[0], req_resp[1]} !== '0) begin
      errors++; $display("FAIL reset_req_side got %h exp 0", {req_rdy[0], req_rdy[1], req_resp[0], req_resp[1]});
    end
    clear_inputs();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_writes();
    logic [31:0] a, d;
    do_reset();
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    for (int k = 0; k < 3; k++) begin
      a = 32'h1000 + 32'(k) * 32'h10;
      d = 32'hA5A5_0000 + 32'(k);
      @(negedge clk);
      req[0] = 1'b1;
      req_wr[0] = '{awaddr: a, awvalid: 1'b1, wdata: d, wstrb: 4'hF, wvalid: 1'b1};
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL single_idle_grant k=%0d got %b exp 00", k, grant); end
      @(negedge clk); #1;
      checks++; if (grant !== 2'b01) begin errors++; $display("FAIL single_addr_grant k=%0d got %b exp 01", k, grant); end
      checks++; if (m_wr.awaddr !== a || m_wr.awvalid !== 1'b1 || m_wr.wvalid !== 1'b0) begin
        errors++; $display("FAIL single_aw k=%0d got %h/%b/%b exp %h/1/0", k, m_wr.awaddr, m_wr.awvalid, m_wr.wvalid, a);
      end
      checks++; if (req_rdy[0].awready !== 1'b1) begin errors++; $display("FAIL single_awready k=%0d got %b exp 1", k, req_rdy[0].awready); end
      checks++; if (outstanding !== 4'(k)) begin errors++; $display("FAIL single_out_addr k=%0d got %0d exp %0d", k, outstanding, k); end
      @(negedge clk); #1;
      checks++; if (m_wr.wvalid !== 1'b1 || m_wr.awvalid !== 1'b0 || m_wr.wdata !== d || m_wr.wstrb !== 4'hF) begin
        errors++; $display("FAIL single_w k=%0d got %b/%b/%h/%h exp 1/0/%h/f", k, m_wr.wvalid, m_wr.awvalid, m_wr.wdata, m_wr.wstrb, d);
      end
      checks++; if (req_rdy[0].wready !== 1'b1) begin errors++; $display("FAIL single_wready k=%0d got %b exp 1", k, req_rdy[0].wready); end
      checks++; if (outstanding !== 4'(k + 1)) begin errors++; $display("FAIL single_out_data k=%0d got %0d exp %0d", k, outstanding, k + 1); end
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      req = '0;
      req_wr[0] = '0;
      m_resp = '{bvalid: 1'b1, bresp: 2'b00};
      #1;
      checks++; if (req_resp[0].bvalid !== 1'b1 || req_resp[1].bvalid !== 1'b0) begin
        errors++; $display("FAIL single_b k=%0d got %b%b exp 10", k, req_resp[0].bvalid, req_resp[1].bvalid);
      end
      checks++; if (outstanding !== 4'(3 - k)) begin errors++; $display("FAIL single_out_b k=%0d got %0d exp %0d", k, outstanding, 3 - k); end
    end
    @(negedge clk);
    m_resp = '0;
    #1;
    checks++; if (outstanding !== 4'd0 || err !== 1'b0) begin
      errors++; $display("FAIL single_drained got out=%0d err=%b exp 0/0", outstanding, err);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g [4];
    logic [1:0] other;
`ifdef HAWK_WR_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    do_reset();
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    req = 2'b11;
    req_wr[0] = '{awaddr: 32'h100, awvalid: 1'b1, wdata: 32'h0000_00A0, wstrb: 4'hF, wvalid: 1'b1};
    req_wr[1] = '{awaddr: 32'h200, awvalid: 1'b1, wdata: 32'h0000_00B1, wstrb: 4'h3, wvalid: 1'b1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (grant !== exp_g[k]) begin errors++; $display("FAIL rr_grant k=%0d got %b exp %b", k, grant, exp_g[k]); end
      checks++; if (m_wr.wdata !== (exp_g[k] == 2'b01 ? 32'h0000_00A0 : 32'h0000_00B1)) begin
        errors++; $display("FAIL rr_data k=%0d got %h", k, m_wr.wdata);
      end
      @(negedge clk);
      @(negedge clk);
      if (k == 3) req = '0;
      #1;
      checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rr_idle_gap k=%0d got %b exp 00", k, grant); end
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      m_resp = '{bvalid: 1'b1, bresp: 2'b00};
      #1;
      other = {req_resp[1].bvalid, req_resp[0].bvalid};
      checks++; if (other !== exp_g[k]) begin errors++; $display("FAIL rr_b_route k=%0d got %b exp %b", k, other, exp_g[k]); end
    end
    @(negedge clk);
    m_resp = '0;
    #1;
    checks++; if (outstanding !== 4'd0) begin errors++; $display("FAIL rr_drained got %0d exp 0", outstanding); end
  endtask

  task automatic test_wready_stall();
    do_reset();
    m_rdy = '{awready: 1'b1, wready: 1'b0};
    req = 2'b11;
    req_wr[0] = '{awaddr: 32'h300, awvalid: 1'b1, wdata: 32'h3, wstrb: 4'hF, wvalid: 1'b1};
    req_wr[1] = '{awaddr: 32'h400, awvalid: 1'b1, wdata: 32'h4, wstrb: 4'hF, wvalid: 1'b1};
    @(negedge clk); #1;
    checks++; if (grant !== 2'b01 || req_rdy[1].awready !== 1'b0) begin
      errors++; $display("FAIL stall_addr got grant=%b aw1=%b exp 01/0", grant, req_rdy[1].awready);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      checks++; if (grant !== 2'b01 || req_rdy[1].awready !== 1'b0 || req_rdy[0].wready !== 1'b0) begin
        errors++; $display("FAIL stall_hold i=%0d got grant=%b aw1=%b w0=%b exp 01/0/0", i, grant, req_rdy[1].awready, req_rdy[0].wready);
      end
    end
    @(negedge clk);
    m_rdy.wready = 1'b1;
    #1;
    checks++; if (req_rdy[0].wready !== 1'b1) begin errors++; $display("FAIL stall_release got %b exp 1", req_rdy[0].wready); end
    @(negedge clk);
    req[0] = 1'b0;
    req_wr[0] = '0;
    #1;
    checks++; if (grant !== 2'b00) begin errors++; $display("FAIL stall_idle got %b exp 00", grant); end
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL stall_next_owner got %b exp 10", grant); end
    req = '0;
    req_wr[1] = '0;
    @(negedge clk); #1;
    checks++; if (grant !== 2'b00 || outstanding !== 4'd1) begin
      errors++; $display("FAIL addr_abandon got grant=%b out=%0d exp 00/1", grant, outstanding);
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    req[0] = 1'b1;
    req_wr[0] = '{awaddr: 32'h500, awvalid: 1'b1, wdata: 32'h5, wstrb: 4'hF, wvalid: 1'b1};
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
    end
    @(negedge clk); #1;
    checks++; if (req_rdy[0].awready !== 1'b0 || m_wr.awvalid !== 1'b0 || outstanding !== 4'd8 || grant !== 2'b01) begin
      errors++; $display("FAIL full_stall got aw=%b mav=%b out=%0d grant=%b exp 0/0/8/01", req_rdy[0].awready, m_wr.awvalid, outstanding, grant);
    end
    @(negedge clk); #1;
    checks++; if (req_rdy[0].awready !== 1'b0) begin errors++; $display("FAIL full_stall2 got %b exp 0", req_rdy[0].awready); end
    @(negedge clk);
    m_resp = '{bvalid: 1'b1, bresp: 2'b00};
    #1;
    checks++; if (req_resp[0].bvalid !== 1'b1 || req_rdy[0].awready !== 1'b0) begin
      errors++; $display("FAIL full_pop_cycle got b=%b aw=%b exp 1/0", req_resp[0].bvalid, req_rdy[0].awready);
    end
    @(negedge clk);
    m_resp = '0;
    #1;
    checks++; if (req_rdy[0].awready !== 1'b1 || outstanding !== 4'd7) begin
      errors++; $display("FAIL full_resume got aw=%b out=%0d exp 1/7", req_rdy[0].awready, outstanding);
    end
    @(negedge clk);
    req = '0;
    req_wr[0].awvalid = 1'b0;
    #1;
    checks++; if (outstanding !== 4'd8) begin errors++; $display("FAIL full_refill got %0d exp 8", outstanding); end
  endtask

  task automatic test_err();
    do_reset();
    @(negedge clk);
    m_resp = '{bvalid: 1'b1, bresp: 2'b00};
    #1;
    checks++; if (err !== 1'b0 || req_resp[0].bvalid !== 1'b0 || req_resp[1].bvalid !== 1'b0) begin
      errors++; $display("FAIL err_empty_route got err=%b b=%b%b exp 0/00", err, req_resp[1].bvalid, req_resp[0].bvalid);
    end
    @(negedge clk);
    m_resp = '0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_empty_set got %b exp 1", err); end
    @(negedge clk); #1;
    checks++; if (err !== 1'b1 || outstanding !== 4'd0) begin
      errors++; $display("FAIL err_sticky got err=%b out=%0d exp 1/0", err, outstanding);
    end
    do_reset();
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_cleared got %b exp 0", err); end
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    req[1] = 1'b1;
    req_wr[1] = '{awaddr: 32'h600, awvalid: 1'b1, wdata: 32'h6, wstrb: 4'hF, wvalid: 1'b1};
    @(negedge clk); #1;
    checks++; if (grant !== 2'b10) begin errors++; $display("FAIL err_owner got %b exp 10", grant); end
    @(negedge clk);
    @(negedge clk);
    req = '0;
    req_wr[1] = '0;
    m_resp = '{bvalid: 1'b1, bresp: 2'b10};
    #1;
    checks++; if (req_resp[1].bvalid !== 1'b1 || req_resp[1].bresp !== 2'b10 || req_resp[0].bvalid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL slverr_route got b1=%b r1=%b b0=%b err=%b exp 1/10/0/0", req_resp[1].bvalid, req_resp[1].bresp, req_resp[0].bvalid, err);
    end
    @(negedge clk);
    m_resp = '0;
    #1;
    checks++; if (err !== 1'b1 || outstanding !== 4'd0) begin
      errors++; $display("FAIL slverr_set got err=%b out=%0d exp 1/0", err, outstanding);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    m_resp = '{bvalid: 1'b1, bresp: 2'b00};
    @(negedge clk);
    m_resp = '0;
    m_rdy = '{awready: 1'b1, wready: 1'b1};
    req[0] = 1'b1;
    req_wr[0] = '{awaddr: 32'h700, awvalid: 1'b1, wdata: 32'h7, wstrb: 4'hF, wvalid: 1'b1};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
    end
    m_rdy.wready = 1'b0;
    @(negedge clk);
    @(negedge clk); #1;
    checks++; if (outstanding !== 4'd3 || grant !== 2'b01 || err !== 1'b1 || m_wr.wvalid !== 1'b1) begin
      errors++; $display("FAIL mid_setup got out=%0d grant=%b err=%b wv=%b exp 3/01/1/1", outstanding, grant, err, m_wr.wvalid);
    end
    #1;
    rst_ni = 1'b0;
    m_resp = '{bvalid: 1'b1, bresp: 2'b10};
    #1;
    checks++; if (grant !== 2'b00 || outstanding !== 4'd0 || err !== 1'b0) begin
      errors++; $display("FAIL mid_reset_ctrl got grant=%b out=%0d err=%b exp 00/0/0", grant, outstanding, err);
    end
    checks++; if (m_wr !== '0 || {req_rdy[0], req_rdy[1], req_resp[0], req_resp[1]} !== '0) begin
      errors++; $display("FAIL mid_reset_bus got m_wr=%h side=%h exp 0/0", m_wr, {req_rdy[0], req_rdy[1], req_resp[0], req_resp[1]});
    end
    @(negedge clk);
    clear_inputs();
    rst_ni = 1'b1;
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_writes();
    test_round_robin();
    test_wready_stall();
    test_fifo_full();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1);
  end

endmodule

// File: doc/hawk_wr_arbiter.md
# hawk_wr_arbiter

Shares the single HAWK AXI write master port among `NUM_REQ` write requesters: the page-write manager, the compression write-back path, and future table writers. It grants ownership of the AW/W channels to one requester at a time and keeps AW and W of each transaction atomic. It records each issued transaction's owner in an in-order ID FIFO and routes B responses back to the owner. It sits between the requester-side `axi_wr_*pkt_t` bundles and the HAWK AXI master.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters; requester 0 is the page-write manager.
- `RESP_DEPTH`, default 8: ID FIFO depth, which is the maximum number of outstanding writes awaiting B.

Ports:
- `clk_i`, input, 1: clock.
- `rst_ni`, input, 1: reset; asynchronous, active-low.
- `req_i`, input, `NUM_REQ`: level request per requester; high while the requester wants the bus.
- `req_wr_i`, input, `axi_wr_reqpkt_t` [`NUM_REQ`]: requester addr/data/strb/awvalid/wvalid.
- `req_rdy_o`, output, `axi_wr_rdypkt_t` [`NUM_REQ`]: awready/wready returned per requester.
- `req_resp_o`, output, `axi_wr_resppkt_t` [`NUM_REQ`]: bvalid/bresp routed per requester.
- `m_wr_o`, output, `axi_wr_reqpkt_t`: downstream request.
- `m_rdy_i`, input, `axi_wr_rdypkt_t`: downstream awready/wready.
- `m_resp_i`, input, `axi_wr_resppkt_t`: downstream bvalid/bresp; bready is implicitly always 1.
- `grant_o`, output, `NUM_REQ`: one-hot current owner; all-zero when the arbiter is in IDLE.
- `outstanding_o`, output, `clog2(RESP_DEPTH)+1`: current ID FIFO occupancy.
- `err_o`, output, 1: sticky error.

## Operation
State machine has three states: IDLE, ADDR, DATA.
- **IDLE**
  - If any `req_i` bit is set, select the owner round-robin, searching from `rr_ptr`.
  - Register the owner in `grant_o` and go to ADDR.
  - If no `req_i` bit is set, stay in IDLE.
- **ADDR**
  - Owner's awready = `m_rdy_i.awready` AND NOT fifo_full. Every other requester sees awready=0 and wready=0.
  - `m_wr_o` carries the owner's addr/data/strb/awvalid. `m_wr_o.awvalid` is also gated by NOT fifo_full.
  - On owner awvalid with forwarded awready: push the owner index into the ID FIFO and go to DATA.
  - If the owner drops `req_i` while in ADDR without sending awvalid, return to IDLE.
- **DATA**
  - Owner's wready = `m_rdy_i.wready`. Owner's wvalid is forwarded to `m_wr_o.wvalid`.
  - On the W handshake: set `rr_ptr` = owner+1 modulo `NUM_REQ`, clear `grant_o`, go to IDLE.
  - Exactly one W beat is allowed per AW.
- **B routing**
  - `m_resp_i.bvalid` is forwarded to `req_resp_o[fifo_head]` with bresp, in the same cycle.
  - The FIFO pops on that cycle. All other requesters see bvalid=0.
- **err_o** is set on either of:
  - bvalid while the FIFO is empty (a response is still popped for nothing; no requester sees it);
  - bresp ≠ 0, which is still routed to the owner.
  - It is cleared only by reset.
- **Push and pop in the same cycle:** occupancy is unchanged. A push while full cannot happen, because awready is gated by fifo_full.

## Timing
- Arbitration costs 1 cycle: IDLE → ADDR. A transaction whose `req_i` is already high takes ≥3 cycles from grant to return to IDLE.
- AW/W/B muxing is combinational: zero added latency from requester to master.
- Minimum spacing between grants to different requesters is 1 IDLE cycle.
- Reset values:
  - state IDLE, `rr_ptr`=0, `grant_o`=0;
  - all `req_rdy_o` and `req_resp_o` fields 0;
  - `m_wr_o` valids 0 and payload 0;
  - FIFO empty, `outstanding_o`=0, `err_o`=0.
- Reset asserted mid-transaction: everything returns to the reset values asynchronously; outstanding IDs are discarded.
- Wrap-around: `rr_ptr` wraps `NUM_REQ`-1 → 0. FIFO read/write pointers wrap modulo `RESP_DEPTH`.

## Configuration
- `HAWK_WR_ARB_FIXED_PRIO_EN` defined: IDLE always picks the lowest-index requesting `req_i`, so requester 0 has top priority. `rr_ptr` is not implemented.
- Macro undefined: round-robin as described above.

## Structure
- The following belong in `hacd_pkg`:
  - `wr_arb_state_t` enum (IDLE/ADDR/DATA);
  - the `axi_wr_*pkt_t` types (already there);
  - `REQ_PGWR`=0 and `REQ_CWB`=1 index constants.
- Sub-module `hawk_wr_arb_idfifo`: synchronous FIFO, width clog2(`NUM_REQ`), depth `RESP_DEPTH`, with full/empty/count outputs.

## Test plan
- Only req 0 issues 3 writes, downstream always ready → 3 AW/W pairs forwarded with data unchanged; 3 B responses routed to req 0; `outstanding_o` goes 0→1→… and back to 0.
- req 0 and req 1 held high continuously, round-robin build → grants alternate 0,1,0,1. With `HAWK_WR_ARB_FIXED_PRIO_EN` → req 0 is granted every time.
- `m_rdy_i.wready` held 0 for 5 cycles in DATA → `grant_o` stays on the owner; req 1's awready stays 0; the arbiter advances one cycle after wready rises.
- Hold bvalid=0 with `RESP_DEPTH`=8; issue 8 writes → the 9th AW is stalled with awready=0. Inject one bvalid → awready returns the next cycle.
- bvalid with the FIFO empty → `err_o`=1 and stays set. bresp=2'b10 → routed to the owner and `err_o`=1.
- Deassert `rst_ni` while in DATA with 3 writes outstanding → all outputs return to reset values and `outstanding_o`=0.
